// File: rtl/alu_pkg.sv
// Shared definitions for the UART ALU: opcodes, response-frame header constants
// and the response transmitter state encoding.
package alu_pkg;

  typedef enum logic [7:0] {
    OpAdd = 8'h01,
    OpSub = 8'h02,
    OpAnd = 8'h03,
    OpOr  = 8'h04,
    OpXor = 8'h05,
    OpShl = 8'h06,
    OpShr = 8'h07,
    OpMul = 8'hA0
  } alu_opcode_e;

  localparam logic [7:0] RESERVED_BYTE = 8'h00;
  localparam int         HEADER_BYTES  = 4;

  typedef enum logic [0:0] {
    TxIdle = 1'b0,
    TxSend = 1'b1
  } tx_state_e;

endpackage

// File: rtl/alu_resp_tx.sv
// Response-packet serializer: captures one ALU result with its opcode and streams
// a header (opcode, reserved, 16-bit length) followed by the result LSB first.
module alu_resp_tx
  import alu_pkg::*;
#(
  parameter int WIDTH_P = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [7:0]         opcode_i,
  input  logic [WIDTH_P-1:0] result_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [7:0]         data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int                NUM_BYTES = HEADER_BYTES + WIDTH_P / 8;
  localparam logic [15:0]       LEN_C     = 16'(NUM_BYTES);
  localparam int                IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);

  tx_state_e          r_state;
  logic [IDX_W-1:0]   r_index;
  logic [7:0]         r_opcode;
  logic [WIDTH_P-1:0] r_result;
  logic               r_valid;
  logic               r_ready;

  // Frame byte selected by position; header first, then the result LSB first.
  function automatic logic [7:0] byteAt(input logic [IDX_W-1:0]   idx,
                                        input logic [7:0]         op,
                                        input logic [WIDTH_P-1:0] res);
    logic [WIDTH_P-1:0] w_shifted;
    w_shifted = '0;
    case (int'(idx))
      0:       byteAt = op;
      1:       byteAt = RESERVED_BYTE;
      2:       byteAt = LEN_C[7:0];
      3:       byteAt = LEN_C[15:8];
      default: begin
        w_shifted = res >> (8 * (int'(idx) - HEADER_BYTES));
        byteAt    = w_shifted[7:0];
      end
    endcase
  endfunction

  // ready_o is registered so it stays low during reset and rises one edge later.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= TxIdle;
      r_index  <= '0;
      r_opcode <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        TxIdle: begin
          if (valid_i && r_ready) begin
            r_opcode <= opcode_i;
            r_result <= result_i;
            r_index  <= '0;
            r_valid  <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= TxSend;
          end else begin
            r_ready  <= 1'b1;
          end
        end
        TxSend: begin
          if (ready_i) begin
            if (r_index == LAST_IDX) begin
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_state <= TxIdle;
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b0;
          r_state <= TxIdle;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign data_o  = byteAt(r_index, r_opcode, r_result);

endmodule

// File: tb/tb_alu_resp_tx.sv
// Directed bench for alu_resp_tx: table-driven 32-bit frames plus hand-written
// sequences for input changes mid-frame, asynchronous reset and 8-bit spacing.
module tb_alu_resp_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst;
  logic [7:0]  op32;
  logic [31:0] res32;
  logic        valid32, ready32o, valid32o, ready32i;
  logic [7:0]  data32;
  logic [7:0]  op8;
  logic [7:0]  res8;
  logic        valid8, ready8o, valid8o, ready8i;
  logic [7:0]  data8;

  int checks   = 0;
  int failures = 0;

  alu_resp_tx #(.WIDTH_P(32)) dut32 (
    .clk_i(clock), .reset_i(rst), .opcode_i(op32), .result_i(res32),
    .valid_i(valid32), .ready_o(ready32o), .data_o(data32),
    .valid_o(valid32o), .ready_i(ready32i)
  );

  alu_resp_tx #(.WIDTH_P(8)) dut8 (
    .clk_i(clock), .reset_i(rst), .opcode_i(op8), .result_i(res8),
    .valid_i(valid8), .ready_o(ready8o), .data_o(data8),
    .valid_o(valid8o), .ready_i(ready8i)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] res;
    int          mode;
    logic [63:0] expBytes;
  } frameVec_t;

  frameVec_t vecs [4];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for ready_o, then presents one result for a single capture edge.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] res);
    int n;
    n = 0;
    @(negedge clock);
    while (!ready32o && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ready32o) checkOutput("readyTimeout", 64'(ready32o), 64'd1);
    valid32 = 1'b1;
    op32    = op;
    res32   = res;
    @(posedge clock);
    #1 valid32 = 1'b0;
  endtask

  // Collects nBytes of a 32-bit frame; mode 1 stalls on every other cycle.
  task automatic collect32(input logic [63:0] expBytes, input int mode,
                           input int nBytes, input bit endCheck);
    int k, cyc;
    bit stalled;
    logic [7:0] held;
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k < nBytes && cyc < 64) begin
      @(negedge clock);
      if (stalled) begin
        checkOutput("stallData", 64'(data32), 64'(held));
        checkOutput("stallValid", 64'(valid32o), 64'd1);
      end
      checkOutput("sendValid", 64'(valid32o), 64'd1);
      checkOutput("sendReadyLow", 64'(ready32o), 64'd0);
      ready32i = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
      if (ready32i) begin
        checkOutput("frameByte", 64'(data32), 64'(expBytes[8*k +: 8]));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = data32;
      end
      cyc++;
    end
    if (k < nBytes) checkOutput("frameTimeout", 64'(k), 64'(nBytes));
    ready32i = 1'b1;
    if (endCheck) begin
      @(negedge clock);
      checkOutput("endValid", 64'(valid32o), 64'd0);
      checkOutput("endReady", 64'(ready32o), 64'd1);
    end
  endtask

  // Safety net so a stuck DUT still ends the run with a summary.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got timeout, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lastReady, pulses, pos, idleValid;
    logic [39:0] exp8;

    vecs[0] = '{op: 8'hA0, res: 32'h12345678, mode: 0, expBytes: 64'h12345678_0008_00A0};
    vecs[1] = '{op: 8'hA0, res: 32'h12345678, mode: 1, expBytes: 64'h12345678_0008_00A0};
    vecs[2] = '{op: 8'h5A, res: 32'h80000001, mode: 1, expBytes: 64'h80000001_0008_005A};
    vecs[3] = '{op: 8'h01, res: 32'h00000000, mode: 0, expBytes: 64'h00000000_0008_0001};

    rst = 1'b1;
    op32 = '0; res32 = '0; valid32 = 1'b0; ready32i = 1'b1;
    op8 = '0; res8 = '0; valid8 = 1'b0; ready8i = 1'b1;
    #1;
    checkOutput("resetReady", 64'(ready32o), 64'd0);
    checkOutput("resetValid", 64'(valid32o), 64'd0);
    checkOutput("resetData", 64'(data32), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("postResetReady", 64'(ready32o), 64'd1);
    checkOutput("postResetValid", 64'(valid32o), 64'd0);
    checkOutput("postResetReady8", 64'(ready8o), 64'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].op, vecs[i].res);
      collect32(vecs[i].expBytes, vecs[i].mode, 8, 1'b1);
    end

    // New request held high while a frame is in flight; it must wait for Idle.
    applyStimulus(8'hA0, 32'h12345678);
    valid32 = 1'b1;
    op32    = 8'hFF;
    res32   = 32'hDEADBEEF;
    collect32(64'h12345678_0008_00A0, 0, 8, 1'b1);
    @(posedge clock);
    #1 valid32 = 1'b0;
    collect32(64'hDEADBEEF_0008_00FF, 0, 8, 1'b1);

    // Asynchronous reset between clock edges after three bytes have gone out.
    applyStimulus(8'hA0, 32'h12345678);
    collect32(64'h12345678_0008_00A0, 0, 3, 1'b0);
    @(posedge clock);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncResetValid", 64'(valid32o), 64'd0);
    checkOutput("asyncResetReady", 64'(ready32o), 64'd0);
    checkOutput("asyncResetData", 64'(data32), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("releaseReady", 64'(ready32o), 64'd1);
    idleValid = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (valid32o) idleValid++;
    end
    checkOutput("residualBytes", 64'(idleValid), 64'd0);

    // 8-bit instance with valid_i held high: frames repeat every 6 cycles.
    exp8 = 40'h7F_0005_0001;
    ready8i = 1'b1;
    @(negedge clock);
    valid8 = 1'b1;
    op8    = 8'h01;
    res8   = 8'h7F;
    lastReady = -1; pulses = 0; pos = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (ready8o) begin
        if (lastReady >= 0) checkOutput("spacing8", 64'(c - lastReady), 64'd6);
        lastReady = c;
        pulses++;
      end
      if (valid8o) begin
        checkOutput("frameByte8", 64'(data8), 64'(exp8[8*pos +: 8]));
        pos = (pos + 1) % 5;
      end
    end
    checkOutput("pulses8", 64'(pulses >= 3), 64'd1);
    valid8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_resp_tx.md
# alu_resp_tx

Response-packet serializer for the UART ALU: the transmit-side counterpart of the command-packet parser. It accepts one ALU result plus the opcode that produced it, builds a response frame (4-byte header, then the result least-significant byte first), and streams it one byte at a time to the UART transmitter over a valid/ready byte interface. It sits between the ALU datapath and the UART TX.

## Interface
- WIDTH_P, 32, result width in bits; must be a multiple of 8, range 8..64
- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  asynchronous, active-high reset
- opcode_i  input  8  opcode echoed in response header
- result_i  input  WIDTH_P  ALU result to send
- valid_i  input  1  opcode_i/result_i valid
- ready_o  output  1  block can accept a result
- data_o  output  8  outgoing byte to UART TX
- valid_o  output  1  data_o valid
- ready_i  input  1  UART TX accepts data_o this cycle

## Operation
- Frame, in order: opcode, 0x00 (reserved), length LSB, length MSB, result bytes [7:0], [15:8], …, MSB byte last.
- Length = 4 + WIDTH_P/8, 16-bit little-endian; it counts the header. For WIDTH_P=32 the header length bytes are 0x08, 0x00, and the frame is 8 bytes.
- States:
  - Idle: ready_o=1, valid_o=0. On valid_i&ready_o, capture opcode_i and result_i into internal registers, clear the byte index, go to Send.
  - Send: valid_o=1, data_o = byte[index]. On valid_o&ready_i, increment the index. If the accepted byte is the last byte (index = length−1), go to Idle.
- Byte index is a counter wide enough for length−1. It never wraps within a frame and clears on capture.
- Captured values are frozen for the whole frame. Changes on opcode_i/result_i after capture have no effect.
- Inputs are ignored outside Idle; ready_o=0 there.
- ready_i may toggle arbitrarily. data_o and valid_o stay stable while valid_o=1 and ready_i=0.
- Reset values (asynchronous, held while reset_i=1): state Idle, index 0, captured registers 0, valid_o=0, data_o=0x00, ready_o=0. ready_o rises the first cycle after reset_i deasserts.
- Reset mid-frame aborts immediately. The partial frame is lost and nothing resumes after release.

## Timing
- Capture on edge N. valid_o=1 with data_o=opcode from edge N onward, so the first byte is offered in cycle N+1.
- With ready_i held high, byte k is accepted on edge N+1+k and the last byte on edge N+length.
- Last-byte accept edge returns to Idle. ready_o=1 the following cycle.
- Minimum spacing between captures is length+1 cycles (9 for WIDTH_P=32).
- No combinational path from valid_i to valid_o, or from ready_i to ready_o.
- A path from ready_i to the next-state logic only is acceptable.
- data_o may be a mux of captured registers indexed by the registered index (no extra latency).

## Structure
- Shared package alu_pkg holds:
  - opcode enum (shared with the command parser)
  - RESERVED_BYTE = 8'h00
  - HEADER_BYTES = 4
  - the tx state enum (Idle, Send)
- Length is computed from WIDTH_P and HEADER_BYTES inside the module.
- No sub-module: a single FSM plus the index counter and capture registers. The byte mux is an in-module function.

## Test plan
- Reset then single frame, WIDTH_P=32, opcode 0xA0, result 0x12345678, ready_i=1:
  - ready_o=1 first cycle after reset.
  - Bytes A0 00 08 00 78 56 34 12 on 8 consecutive edges.
  - ready_o=1 again on the 9th cycle.
- Backpressure, same frame with ready_i low on alternate cycles:
  - Identical byte sequence.
  - data_o/valid_o stable on every stalled cycle.
  - No byte duplicated or dropped.
- Input change during Send:
  - Drive valid_i=1, opcode 0xFF, result 0xDEADBEEF while frame 1 is in flight.
  - ready_o=0 throughout; frame 1 bytes unchanged.
  - The new value is captured on the first Idle cycle and produces FF 00 08 00 EF BE AD DE.
- Asynchronous reset asserted mid-edge-free after byte 3 accepted:
  - valid_o=0 and ready_o=0 immediately, without waiting for a clock edge.
  - After release, Idle with ready_o=1, and no residual bytes emitted.
- WIDTH_P=8, opcode 0x01, result 0x7F:
  - Frame 01 00 05 00 7F.
  - Back-to-back valid_i yields 6-cycle frame spacing with ready_i=1.
